spi_slave_cfg: RTL and testbench

SPI_SLAVE_CFG -- requirements
Module: spi_slave_cfg

---
 rtl/spi_slave_cfg.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_slave_cfg.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_cfg.sv
// -----------------------------------------------------------------------------
// spi_slave_cfg
//
// SPI slave with configurable frame length, SPI mode and bit order.
//
// The asynchronous SPI pins (ss, sclk, mosi) are brought into the clk domain
// through 2-flop synchronizers. sclk edges are found by comparing the
// synchronized sclk with a copy delayed by one clk. A single-entry transmit
// buffer feeds each frame. Every complete frame is published on rx_data with
// a one-clk rx_valid pulse.
//
// Parameters
//   FRAME_BITS : bits per frame, 2..32
//   SPI_MODE   : 0..3, CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
//   MSB_FIRST  : 1 = MSB first on mosi/miso, 0 = LSB first
//
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset
//   ss          : slave select, active low (async to clk)
//   sclk        : SPI serial clock (async to clk)
//   mosi        : serial data from the master
//   miso        : serial data to the master, 0 while idle
//   tx_data     : word for the next transmitted frame
//   tx_load     : write strobe for tx_data
//   tx_ready    : transmit buffer empty
//   rx_data     : last complete received frame
//   rx_valid    : one-clk pulse marking a new rx_data
//   busy        : a frame is in progress
//   tx_underrun : frame started with the transmit buffer empty
//
// Optional feature
//   SPI_SLAVE_CFG_UNDERRUN_EN : when defined, tx_underrun pulses for one clk
//   whenever a frame loads from an empty buffer. When undefined, tx_underrun
//   is tied 0. An empty buffer always shifts out zeros.
// -----------------------------------------------------------------------------
module spi_slave_cfg #(
  parameter int FRAME_BITS = 20,
  parameter int SPI_MODE   = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ss,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam bit CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA = (SPI_MODE % 2) == 1;
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Bit-order helpers: the bit that goes out first, the word after that bit
  // has gone out, and the receive word after a new bit comes in.
  function automatic logic first_bit(input logic [FRAME_BITS-1:0] w);
    if (MSB_FIRST != 0) return w[FRAME_BITS-1];
    else                return w[0];
  endfunction

  function automatic logic [FRAME_BITS-1:0] drop_bit(input logic [FRAME_BITS-1:0] w);
    if (MSB_FIRST != 0) return {w[FRAME_BITS-2:0], 1'b0};
    else                return {1'b0, w[FRAME_BITS-1:1]};
  endfunction

  function automatic logic [FRAME_BITS-1:0] push_bit(input logic [FRAME_BITS-1:0] w,
                                                      input logic b);
    if (MSB_FIRST != 0) return {w[FRAME_BITS-2:0], b};
    else                return {b, w[FRAME_BITS-1:1]};
  endfunction

  // Synchronizers. ss resets to "low" and is only trusted once it has been
  // seen high (ss_armed_q), so a frame never starts from an ss that was
  // already low when reset was released. sclk resets to its idle level so
  // that reset release does not look like an edge.
  logic ss_meta_q, ss_sync_q;
  logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      sclk_meta_q <= CPOL;
      sclk_sync_q <= CPOL;
      sclk_dly_q  <= CPOL;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ss_meta_q   <= ss;
      ss_sync_q   <= ss_meta_q;
      sclk_meta_q <= sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic sclk_rise, sclk_fall, sample_edge, shift_edge;
  assign sclk_rise   = sclk_sync_q & ~sclk_dly_q;
  assign sclk_fall   = ~sclk_sync_q & sclk_dly_q;
  assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [FRAME_BITS-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q, busy_d;
  logic                  ss_armed_q, ss_armed_d;
  logic                  frame_load;
  logic [FRAME_BITS-1:0] load_word;

  // An empty buffer sends zeros.
  assign load_word = tx_ready_q ? '0 : tx_buf_q;

  // Frame FSM. miso already holds the first bit when the frame loads, so
  // the shift edge only advances it once a bit has been sampled
  // (count != 0). That one rule suppresses the leading shift edge in CPHA=1
  // and the trailing shift edge of the previous frame in back-to-back CPHA=0.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    frame_load = 1'b0;
    ss_armed_d = ss_armed_q | ss_sync_q;

    case (state_q)
      IDLE: begin
        miso_d  = 1'b0;
        count_d = '0;
        if (!ss_sync_q && ss_armed_q) frame_load = 1'b1;
      end
      ACTIVE: begin
        if (ss_sync_q) begin
          state_d = IDLE;
          count_d = '0;
          miso_d  = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = push_bit(rx_shift_q, mosi_sync_q);
          count_d    = count_q + CW'(1);
          if (count_d == LAST_COUNT) state_d = DONE;
        end else if (shift_edge && (count_q != '0)) begin
          miso_d     = first_bit(tx_shift_q);
          tx_shift_d = drop_bit(tx_shift_q);
        end
      end
      DONE: begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        if (!ss_sync_q) begin
          frame_load = 1'b1;
        end else begin
          state_d = IDLE;
          count_d = '0;
          miso_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        miso_d  = 1'b0;
      end
    endcase

    if (frame_load) begin
      state_d    = ACTIVE;
      count_d    = '0;
      miso_d     = first_bit(load_word);
      tx_shift_d = drop_bit(load_word);
    end
  end

  // Transmit buffer. A frame load frees the buffer in the same cycle, so a
  // coincident tx_load is accepted after the old word has been taken.
  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    if (frame_load) tx_ready_d = 1'b1;
    if (tx_load && (tx_ready_q || frame_load)) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ss_armed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      ss_armed_q <= ss_armed_d;
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

`ifdef SPI_SLAVE_CFG_UNDERRUN_EN
  logic tx_underrun_q, tx_underrun_d;

  // Flag frames that load from an empty buffer.
  always_comb begin
    tx_underrun_d = frame_load & tx_ready_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_underrun_q <= 1'b0;
    else       tx_underrun_q <= tx_underrun_d;
  end

  assign tx_underrun = tx_underrun_q;
`else
  assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_cfg.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_cfg
//
// Drives four spi_slave_cfg instances, one per SPI mode, from a single SPI
// master. The master works in leading/trailing edge terms and captures miso
// at each mode's sample edge. A transaction-level model tracks the transmit
// buffer, the expected miso word, rx_data, and the totals of rx_valid and
// tx_underrun pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave_cfg;

  localparam int FB   = 20;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ss;
  logic          mosi0;
  logic          mosi1;
  logic          tx_load;
  logic [FB-1:0] tx_data;
  logic          sclk_v     [4];
  logic          miso_v     [4];
  logic          tx_ready_v [4];
  logic          rx_valid_v [4];
  logic          busy_v     [4];
  logic          under_v    [4];
  logic [FB-1:0] rx_data_v  [4];

  int checks;
  int errors;

  // Transaction-level model.
  bit            model_ready;
  logic [FB-1:0] model_buf;
  logic [FB-1:0] model_rx;
  logic [FB-1:0] pending_tx;
  int            model_valid;
  int            model_under;
  logic [FB-1:0] got_miso [4];
  int            valid_cnt [4];
  int            under_cnt [4];

  always #5 clk = ~clk;

  // One DUT per mode. CPHA=0 slaves see mosi0, which changes on trailing
  // edges. CPHA=1 slaves see mosi1, which changes on leading edges.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      spi_slave_cfg #(.FRAME_BITS(FB), .SPI_MODE(g), .MSB_FIRST(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .ss          (ss),
        .sclk        (sclk_v[g]),
        .mosi        ((g % 2 == 1) ? mosi1 : mosi0),
        .miso        (miso_v[g]),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready_v[g]),
        .rx_data     (rx_data_v[g]),
        .rx_valid    (rx_valid_v[g]),
        .busy        (busy_v[g]),
        .tx_underrun (under_v[g])
      );
    end
  endgenerate

  // Count every clk where rx_valid or tx_underrun is high. A pulse longer
  // than one clk therefore shows up as extra counts.
  initial begin
    for (int m = 0; m < 4; m++) begin
      valid_cnt[m] = 0;
      under_cnt[m] = 0;
    end
  end

  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_v[m] === 1'b1) valid_cnt[m] <= valid_cnt[m] + 1;
      if (under_v[m] === 1'b1)    under_cnt[m] <= under_cnt[m] + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Phase 0 = idle level (CPOL), phase 1 = after the leading edge.
  task automatic setPhase(input bit p);
    for (int m = 0; m < 4; m++) sclk_v[m] = (m >= 2) ^ p;
  endtask

  // A frame starts: the buffer is consumed, or zeros go out if it is empty.
  task automatic modelFrameStart();
    pending_tx = model_ready ? '0 : model_buf;
    if (model_ready) model_under++;
    model_ready = 1'b1;
  endtask

  task automatic checkUnderrun(input string tag);
    for (int m = 0; m < 4; m++) begin
`ifdef SPI_SLAVE_CFG_UNDERRUN_EN
      checkOutput($sformatf("m%0d %s underrun count", m, tag), under_cnt[m], model_under);
`else
      checkOutput($sformatf("m%0d %s underrun count", m, tag), under_cnt[m], 0);
`endif
    end
  endtask

  task automatic checkReset(input string tag);
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("m%0d %s miso", m, tag), miso_v[m], 0);
      checkOutput($sformatf("m%0d %s tx_ready", m, tag), tx_ready_v[m], 1);
      checkOutput($sformatf("m%0d %s rx_data", m, tag), rx_data_v[m], 0);
      checkOutput($sformatf("m%0d %s rx_valid", m, tag), rx_valid_v[m], 0);
      checkOutput($sformatf("m%0d %s busy", m, tag), busy_v[m], 0);
      checkOutput($sformatf("m%0d %s tx_underrun", m, tag), under_v[m], 0);
    end
  endtask

  task automatic loadTx(input logic [FB-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    if (model_ready) begin
      model_buf   = w;
      model_ready = 1'b0;
    end
    for (int m = 0; m < 4; m++)
      checkOutput($sformatf("m%0d tx_ready after load", m), tx_ready_v[m], model_ready);
  endtask

  // Runs nbits of a frame; ss is left low. A full frame is checked here.
  // Because ss is still low when the slaves finish a full frame, they
  // immediately start the next one, and the model follows that.
  task automatic applyStimulus(input logic [FB-1:0] mw, input int nbits,
                               input bit mid_load, input logic [FB-1:0] lw);
    logic [FB-1:0] exp_tx;
    if (ss) begin
      ss = 1'b0;
      modelFrameStart();
      tick(8);
    end
    exp_tx = pending_tx;
    for (int m = 0; m < 4; m++) begin
      got_miso[m] = '0;
      checkOutput($sformatf("m%0d busy at frame start", m), busy_v[m], 1);
      checkOutput($sformatf("m%0d tx_ready at frame start", m), tx_ready_v[m], model_ready);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi0 = mw[FB-1-i];
      if (mid_load && i == 5) begin
        loadTx(lw);
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      for (int m = 0; m < 4; m += 2) got_miso[m][FB-1-i] = miso_v[m];
      setPhase(1'b1);
      mosi1 = mw[FB-1-i];
      tick(HALF);
      for (int m = 1; m < 4; m += 2) got_miso[m][FB-1-i] = miso_v[m];
      setPhase(1'b0);
    end
    tick(HALF);
    if (nbits == FB) begin
      model_rx = mw;
      model_valid++;
      modelFrameStart();
      for (int m = 0; m < 4; m++) begin
        checkOutput($sformatf("m%0d miso word", m), got_miso[m], exp_tx);
        checkOutput($sformatf("m%0d rx_data", m), rx_data_v[m], mw);
        checkOutput($sformatf("m%0d rx_valid count", m), valid_cnt[m], model_valid);
      end
    end
  endtask

  task automatic endFrame();
    ss = 1'b1;
    tick(4);
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("m%0d busy after ss high", m), busy_v[m], 0);
      checkOutput($sformatf("m%0d miso idle", m), miso_v[m], 0);
      checkOutput($sformatf("m%0d tx_ready idle", m), tx_ready_v[m], model_ready);
      checkOutput($sformatf("m%0d rx_data idle", m), rx_data_v[m], model_rx);
    end
    checkUnderrun("end");
  endtask

  task automatic abortFrame();
    ss = 1'b1;
    tick(3);
    for (int m = 0; m < 4; m++)
      checkOutput($sformatf("m%0d busy 3 clk after abort", m), busy_v[m], 0);
    tick(1);
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("m%0d rx_data after abort", m), rx_data_v[m], model_rx);
      checkOutput($sformatf("m%0d rx_valid count after abort", m), valid_cnt[m], model_valid);
      checkOutput($sformatf("m%0d miso after abort", m), miso_v[m], 0);
    end
    checkUnderrun("abort");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    ss          = 1'b1;
    mosi0       = 1'b0;
    mosi1       = 1'b0;
    tx_load     = 1'b0;
    tx_data     = '0;
    model_ready = 1'b1;
    model_buf   = '0;
    model_rx    = '0;
    pending_tx  = '0;
    model_valid = 0;
    model_under = 0;
    setPhase(1'b0);
    tick(3);
    checkReset("reset");
    reset = 1'b0;
    tick(4);

    $display("[TB] directed frame, all four modes");
    loadTx(20'hA5A5A);
    applyStimulus(20'h3C3C3, FB, 1'b0, '0);
    endFrame();

    $display("[TB] back-to-back frames");
    loadTx(20'h11111);
    applyStimulus(20'h0F1E2, FB, 1'b1, 20'h22222);
    applyStimulus(20'h9ABCD, FB, 1'b0, '0);
    endFrame();

    $display("[TB] frame from empty buffer");
    applyStimulus(20'hFFFFF, FB, 1'b0, '0);
    endFrame();

    $display("[TB] second load while full is ignored");
    loadTx(20'h12345);
    loadTx(20'h54321);
    applyStimulus(20'h80001, FB, 1'b0, '0);
    endFrame();

    $display("[TB] abort after 7 bits");
    loadTx(20'h0F0F0);
    applyStimulus(20'h5A5A5, 7, 1'b0, '0);
    abortFrame();
    loadTx(20'hC0FFE);
    applyStimulus(20'h6B6B6, FB, 1'b0, '0);
    endFrame();

    $display("[TB] reset at bit 10");
    loadTx(20'hBEEF1);
    applyStimulus(20'h13579, 10, 1'b0, '0);
    reset = 1'b1;
    #1;
    model_ready = 1'b1;
    model_buf   = '0;
    model_rx    = '0;
    checkReset("mid-frame reset");
    tick(2);
    reset = 1'b0;
    tick(10);
    for (int m = 0; m < 4; m++)
      checkOutput($sformatf("m%0d no start without fresh ss", m), busy_v[m], 0);
    endFrame();
    loadTx(20'h2468A);
    applyStimulus(20'hACE13, FB, 1'b0, '0);
    endFrame();

    $display("[TB] randomized frames");
    for (int k = 0; k < 8; k++) begin
      if (ss && ($urandom_range(1, 0) == 1)) loadTx(20'($urandom));
      applyStimulus(20'($urandom), FB, ($urandom_range(1, 0) == 1), 20'($urandom));
      if (($urandom_range(1, 0) == 1) || (k == 7)) endFrame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
